fp_add_arbiter: RTL and testbench

FP_ADD_ARBITER -- requirements
Module: fp_add_arbiter

---
 rtl/fp_add_arbiter_pkg.sv | 28 ++
 rtl/fp_add_arbiter_if.sv | 52 +++++
 rtl/fp_add_arbiter_rr_arb3.sv | 28 ++
 rtl/fp_add_arbiter.sv | 123 ++++++++++++
 tb/tb_fp_add_arbiter.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/fp_add_arbiter_pkg.sv
// fp_add_arbiter shared definitions.
// Widths, requester count, mode codes and tag layout.
package fp_add_arbiter_pkg;

  localparam int FP_W = 48;
  localparam int NREQ = 3;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

  typedef logic [1:0] req_id_t;

  typedef struct packed {
    logic    vld;
    req_id_t id;
  } tag_t;

  function automatic logic [NREQ-1:0] id2oh(req_id_t id);
    return 3'b001 << id;
  endfunction

  function automatic req_id_t nxt_ptr(req_id_t id);
    return (id == 2'd2) ? 2'd0 : id + 2'd1;
  endfunction

endpackage

// File: rtl/fp_add_arbiter_if.sv
// fp_add_arbiter bus: requests, responses
// and the shared adder connection.
interface fp_add_arbiter_if #(
  parameter int FP_W = fp_add_arbiter_pkg::FP_W
);
  logic            req0_valid;
  logic [FP_W-1:0] req0_a;
  logic [FP_W-1:0] req0_b;
  logic            req0_mode;
  logic            req0_ready;
  logic            req1_valid;
  logic [FP_W-1:0] req1_a;
  logic [FP_W-1:0] req1_b;
  logic            req1_mode;
  logic            req1_ready;
  logic            req2_valid;
  logic [FP_W-1:0] req2_a;
  logic [FP_W-1:0] req2_b;
  logic            req2_mode;
  logic            req2_ready;
  logic [2:0]      rsp_valid;
  logic [FP_W-1:0] rsp_data;
  logic [FP_W-1:0] fp_in1;
  logic [FP_W-1:0] fp_in2;
  logic            fp_mode;
  logic [FP_W-1:0] fp_out;
  logic [2:0]      inflight;
  logic            idle;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_mode,
    input  req1_valid, req1_a, req1_b, req1_mode,
    input  req2_valid, req2_a, req2_b, req2_mode,
    input  fp_out,
    output req0_ready, req1_ready, req2_ready,
    output rsp_valid, rsp_data,
    output fp_in1, fp_in2, fp_mode,
    output inflight, idle
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_mode,
    output req1_valid, req1_a, req1_b, req1_mode,
    output req2_valid, req2_a, req2_b, req2_mode,
    output fp_out,
    input  req0_ready, req1_ready, req2_ready,
    input  rsp_valid, rsp_data,
    input  fp_in1, fp_in2, fp_mode,
    input  inflight, idle
  );

endinterface

// File: rtl/fp_add_arbiter_rr_arb3.sv
// Three-way round-robin grant.
// Search starts at ptr_i and wraps.
module rr_arb3
  import fp_add_arbiter_pkg::*;
(
  input  logic [2:0] valid_i,
  input  req_id_t    ptr_i,
  output logic [2:0] grant_o
);

  // pick the first valid index at or after ptr
  always_comb begin
    grant_o = 3'b000;
    unique case (ptr_i)
      2'd0: grant_o = valid_i[0] ? 3'b001 :
                      valid_i[1] ? 3'b010 :
                      valid_i[2] ? 3'b100 : 3'b000;
      2'd1: grant_o = valid_i[1] ? 3'b010 :
                      valid_i[2] ? 3'b100 :
                      valid_i[0] ? 3'b001 : 3'b000;
      2'd2: grant_o = valid_i[2] ? 3'b100 :
                      valid_i[0] ? 3'b001 :
                      valid_i[1] ? 3'b010 : 3'b000;
      default: grant_o = 3'b000;
    endcase
  end

endmodule

// File: rtl/fp_add_arbiter.sv
// Shares one pipelined fp adder among three
// requesters; a tag pipe routes each result back.
module fp_add_arbiter
  import fp_add_arbiter_pkg::*;
#(
  parameter int FP_W = fp_add_arbiter_pkg::FP_W,
  parameter int LAT  = 2
) (
  input logic              clock,
  input logic              reset,
  fp_add_arbiter_if.slave  bus
);

  logic [2:0]      req_vld;
  logic [2:0]      grant;
  logic [2:0]      ready;
  logic            accept;
  req_id_t         gnt_id;
  logic [FP_W-1:0] sel_a;
  logic [FP_W-1:0] sel_b;
  logic            sel_m;

  req_id_t         ptr_q, ptr_d;
  logic [2:0]      inflight_q, inflight_d;
  tag_t            tag_q [LAT+1];
  logic [2:0]      rsp_valid_q;
  logic [FP_W-1:0] rsp_data_q;
  logic [FP_W-1:0] fp_in1_q;
  logic [FP_W-1:0] fp_in2_q;
  logic            fp_mode_q;

  assign req_vld = {bus.req2_valid,
                    bus.req1_valid,
                    bus.req0_valid};

  rr_arb3 u_arb (
    .valid_i (req_vld),
    .ptr_i   (ptr_q),
    .grant_o (grant)
  );

  assign ready  = reset ? 3'b000 : grant;
  assign accept = |ready;

  // operand mux and id of the granted requester
  always_comb begin
    gnt_id = 2'd0;
    sel_a  = bus.req0_a;
    sel_b  = bus.req0_b;
    sel_m  = bus.req0_mode;
    unique case (1'b1)
      ready[0]: begin
        gnt_id = 2'd0;
        sel_a  = bus.req0_a;
        sel_b  = bus.req0_b;
        sel_m  = bus.req0_mode;
      end
      ready[1]: begin
        gnt_id = 2'd1;
        sel_a  = bus.req1_a;
        sel_b  = bus.req1_b;
        sel_m  = bus.req1_mode;
      end
      ready[2]: begin
        gnt_id = 2'd2;
        sel_a  = bus.req2_a;
        sel_b  = bus.req2_b;
        sel_m  = bus.req2_mode;
      end
      default: ;
    endcase
  end

  // next pointer and outstanding-op count
  always_comb begin
    ptr_d      = accept ? nxt_ptr(gnt_id) : ptr_q;
    inflight_d = inflight_q
               + {2'b00, accept}
               - {2'b00, |rsp_valid_q};
  end

  // operand regs, tag pipe and response capture
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q       <= 2'd0;
      inflight_q  <= 3'd0;
      rsp_valid_q <= 3'b000;
      rsp_data_q  <= '0;
      fp_in1_q    <= '0;
      fp_in2_q    <= '0;
      fp_mode_q   <= 1'b0;
      for (int i = 0; i <= LAT; i++)
        tag_q[i] <= '0;
    end else begin
      ptr_q      <= ptr_d;
      inflight_q <= inflight_d;
      if (accept) begin
        fp_in1_q  <= sel_a;
        fp_in2_q  <= sel_b;
        fp_mode_q <= sel_m;
      end
      tag_q[0] <= {accept, gnt_id};
      for (int i = 1; i <= LAT; i++)
        tag_q[i] <= tag_q[i-1];
      rsp_valid_q <= tag_q[LAT].vld ?
                     id2oh(tag_q[LAT].id) : 3'b000;
      if (tag_q[LAT].vld)
        rsp_data_q <= bus.fp_out;
    end
  end

  assign bus.req0_ready = ready[0];
  assign bus.req1_ready = ready[1];
  assign bus.req2_ready = ready[2];
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.fp_in1     = fp_in1_q;
  assign bus.fp_in2     = fp_in2_q;
  assign bus.fp_mode    = fp_mode_q;
  assign bus.inflight   = inflight_q;
  assign bus.idle       = (inflight_q == 3'd0);

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed bench for fp_add_arbiter with an
// integer add/sub stub standing in for the adder.
module tb_fp_add_arbiter;
  import fp_add_arbiter_pkg::*;

  localparam int W   = 48;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp_add_arbiter_if #(.FP_W(W)) bus ();

  fp_add_arbiter #(.FP_W(W), .LAT(LAT)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  // adder stub, two-cycle latency
  logic [W-1:0] s1, s2;
  always @(posedge clk) begin
    s1 <= bus.fp_mode ? bus.fp_in1 - bus.fp_in2
                      : bus.fp_in1 + bus.fp_in2;
    s2 <= s1;
  end
  assign bus.fp_out = s2;

  logic [2:0] rdy;
  assign rdy = {bus.req2_ready, bus.req1_ready,
                bus.req0_ready};

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(string nm, logic [63:0] got,
                     logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               nm, got, exp);
    end
  endtask

  task automatic set_req(int i, logic v,
                         logic [W-1:0] a,
                         logic [W-1:0] b, logic m);
    case (i)
      0: begin
        bus.req0_valid = v; bus.req0_a = a;
        bus.req0_b = b; bus.req0_mode = m;
      end
      1: begin
        bus.req1_valid = v; bus.req1_a = a;
        bus.req1_b = b; bus.req1_mode = m;
      end
      default: begin
        bus.req2_valid = v; bus.req2_a = a;
        bus.req2_b = b; bus.req2_mode = m;
      end
    endcase
  endtask

  task automatic clr_all();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req2_valid = 1'b0;
  endtask

  typedef struct {
    int           idx;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         m;
    logic [W-1:0] exp;
  } vec_t;

  vec_t tv [6];

  // one request alone: accept, operands, pulse timing
  task automatic do_single(vec_t v);
    logic [2:0] oh;
    int n;
    oh = 3'b001 << v.idx;
    @(negedge clk);
    set_req(v.idx, 1'b1, v.a, v.b, v.m);
    #1;
    n = 0;
    while (rdy != oh && n < 8) begin
      @(negedge clk); #1; n++;
    end
    chk("single_ready", rdy, oh);
    chk("single_accept_wait", n, 0);
    chk("single_inflight_t0", bus.inflight, 0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) set_req(v.idx, 1'b0, v.a, v.b, v.m);
      #1;
      chk("single_rsp_valid", bus.rsp_valid,
          (k == 4) ? oh : 3'b000);
      if (k == 1) begin
        chk("fp_in1", bus.fp_in1, v.a);
        chk("fp_in2", bus.fp_in2, v.b);
        chk("fp_mode", bus.fp_mode, v.m);
      end
      if (k >= 4)
        chk("single_rsp_data", bus.rsp_data, v.exp);
      chk("single_inflight", bus.inflight,
          (k <= 4) ? 1 : 0);
    end
    chk("single_idle", bus.idle, 1'b1);
  endtask

  logic [W-1:0] cres [3];
  int           inf_a [11];
  int           inf_b [13];
  logic [2:0]   e_rsp;

  initial begin
    tv[0] = '{1, 48'h10, 48'h05, 1'b0, 48'h15};
    tv[1] = '{2, 48'h20, 48'h08, 1'b1, 48'h18};
    tv[2] = '{0, 48'h0, 48'h1, 1'b1,
              48'hFFFF_FFFF_FFFF};
    tv[3] = '{1, 48'hFFFF_FFFF_FFFF, 48'h2, 1'b0,
              48'h1};
    tv[4] = '{2, 48'h8000_0000_0000,
              48'h8000_0000_0000, 1'b0, 48'h0};
    tv[5] = '{0, 48'h1234_5678_9ABC,
              48'h0000_0000_1111, 1'b1,
              48'h1234_5678_89AB};
    cres  = '{48'h3, 48'hF0, 48'hE};
    inf_a = '{0, 1, 2, 3, 4, 4, 4, 3, 2, 1, 0};
    inf_b = '{0, 1, 2, 3, 0, 0, 1, 2, 2, 2, 1, 0, 0};

    set_req(0, 1'b1, 48'h1, 48'h2, MODE_ADD);
    set_req(1, 1'b1, 48'h100, 48'h10, MODE_SUB);
    set_req(2, 1'b1, 48'h7, 48'h7, MODE_ADD);

    // reset state, with every requester valid
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", rdy, 3'b000);
    chk("rst_rsp_valid", bus.rsp_valid, 3'b000);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_fp_in1", bus.fp_in1, 0);
    chk("rst_fp_in2", bus.fp_in2, 0);
    chk("rst_fp_mode", bus.fp_mode, 0);
    chk("rst_inflight", bus.inflight, 0);
    chk("rst_idle", bus.idle, 1'b1);

    // all three valid from reset release
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      if (k == 0) rst = 1'b0;
      if (k == 6) clr_all();
      #1;
      chk("rr_ready", rdy,
          (k < 6) ? (3'b001 << (k % 3)) : 3'b000);
      chk("rr_inflight", bus.inflight, inf_a[k]);
      e_rsp = (k >= 4 && k <= 9) ?
              (3'b001 << ((k - 4) % 3)) : 3'b000;
      chk("rr_rsp_valid", bus.rsp_valid, e_rsp);
      if (e_rsp != 3'b000)
        chk("rr_rsp_data", bus.rsp_data,
            cres[(k - 4) % 3]);
    end
    chk("rr_idle", bus.idle, 1'b1);

    // table of single requests
    for (int i = 0; i < 6; i++)
      do_single(tv[i]);

    // last vector was req0, so ptr is now 1
    for (int k = 0; k <= 7; k++) begin
      @(negedge clk);
      if (k == 0) begin
        set_req(0, 1'b1, 48'h3, 48'h4, MODE_ADD);
        set_req(2, 1'b1, 48'h50, 48'h10, MODE_SUB);
      end
      if (k == 1) bus.req2_valid = 1'b0;
      if (k == 2) bus.req0_valid = 1'b0;
      #1;
      chk("ptr1_ready", rdy,
          (k == 0) ? 3'b100 :
          (k == 1) ? 3'b001 : 3'b000);
      e_rsp = (k == 4) ? 3'b100 :
              (k == 5) ? 3'b001 : 3'b000;
      chk("ptr1_rsp_valid", bus.rsp_valid, e_rsp);
      if (k == 4) chk("ptr1_rsp_data", bus.rsp_data, 48'h40);
      if (k == 5) chk("ptr1_rsp_data", bus.rsp_data, 48'h7);
    end

    // three accepts, reset mid-flight, then recover
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      if (k == 0) set_req(1, 1'b1, 48'h1, 48'h1, MODE_ADD);
      if (k == 3) begin clr_all(); rst = 1'b1; end
      if (k == 4) rst = 1'b0;
      if (k == 5) begin
        set_req(0, 1'b1, 48'h30, 48'h3, MODE_ADD);
        set_req(2, 1'b1, 48'h9, 48'h4, MODE_SUB);
      end
      if (k == 6) bus.req0_valid = 1'b0;
      if (k == 7) bus.req2_valid = 1'b0;
      #1;
      chk("rstm_ready", rdy,
          (k <= 2) ? 3'b010 :
          (k == 5) ? 3'b001 :
          (k == 6) ? 3'b100 : 3'b000);
      chk("rstm_inflight", bus.inflight, inf_b[k]);
      e_rsp = (k == 9)  ? 3'b001 :
              (k == 10) ? 3'b100 : 3'b000;
      chk("rstm_rsp_valid", bus.rsp_valid, e_rsp);
      if (k == 4) begin
        chk("rstm_idle", bus.idle, 1'b1);
        chk("rstm_fp_in1", bus.fp_in1, 0);
        chk("rstm_rsp_data", bus.rsp_data, 0);
      end
      if (k == 9) chk("rstm_data0", bus.rsp_data, 48'h33);
      if (k == 10) chk("rstm_data2", bus.rsp_data, 48'h5);
    end

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
